rom_loader: RTL and testbench

Wishbone bus initiator that copies a contiguous image from SPI serial flash into the mainboard's Wishbone target space: console ROM, GROMs, cartridge ROM, speech ROM or PEB memory. It sits beside the mainboard at the top level and drives the same byte-wide Wishbone port that the host and debug logic use. Each transfer reads `length` bytes from the flash with command 0x03 starting at `flash_base`. Each byte is written to `wb_base` plus its offset, one Wishbone write per byte.

---
 rtl/rom_loader_pkg.sv | 27 ++
 rtl/rom_loader_spi_shifter.sv | 89 ++++++++
 rtl/rom_loader.sv | 167 ++++++++++++++++
 tb/tb_rom_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_loader_pkg
//  Description : Shared definitions for the SPI-flash to Wishbone ROM loader:
//                the flash read opcode, loader state encodings and the bit
//                counts used for the command and data phases.
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_loader_pkg;

    // Serial-flash "read data" opcode, followed by a 24-bit byte address.
    localparam logic [7:0] SPI_CMD_READ = 8'h03;

    // Bit counts handed to the shifter for each SPI phase.
    localparam logic [5:0] CMD_BITS  = 6'd32;
    localparam logic [5:0] BYTE_BITS = 6'd8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_DATA = 3'd2,
        ST_WB   = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

endpackage : rom_loader_pkg
`default_nettype wire

// File: rtl/rom_loader_spi_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_shifter
//  Description : SPI mode-0 bit engine. A one-cycle run_i pulse loads tx_i
//                and the bit count; SCK then toggles every CLK_DIV cycles.
//                MISO is sampled on each SCK rising edge and shifted in on
//                the following falling edge, which also advances MOSI.
//                fin_o pulses in the cycle the last falling edge is visible.
//  Ports       : clk, reset (async, active high)
//                run_i  - load/start pulse      bits_i - bits to transfer
//                tx_i   - transmit word (MSB first)
//                miso_i - serial input          sck_o/mosi_o - serial outputs
//                rx_o   - last 8 bits received  fin_o - completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_i,
    input  logic [5:0]  bits_i,
    input  logic [31:0] tx_i,
    input  logic        miso_i,
    output logic        sck_o,
    output logic        mosi_o,
    output logic [7:0]  rx_o,
    output logic        fin_o
);
    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [31:0]      shift_q;
    logic [DIV_W-1:0] div_q;
    logic [5:0]       cnt_q;
    logic             active_q;
    logic             sck_q;
    logic             samp_q;
    logic             fin_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q  <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            samp_q   <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            if (run_i) begin
                shift_q  <= tx_i;
                div_q    <= '0;
                cnt_q    <= bits_i;
                active_q <= 1'b1;
                sck_q    <= 1'b0;
            end else if (active_q) begin
                if (div_q == DIV_LAST) begin
                    div_q <= '0;
                    sck_q <= ~sck_q;
                    if (!sck_q) begin
                        samp_q <= miso_i;
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                        if (cnt_q == 6'd1) begin
                            // Last edge: clear the MOSI bit so the line idles
                            // low instead of echoing bits sampled from MISO.
                            shift_q  <= {1'b0, shift_q[29:0], samp_q};
                            active_q <= 1'b0;
                            fin_q    <= 1'b1;
                        end else begin
                            shift_q <= {shift_q[30:0], samp_q};
                        end
                    end
                end else begin
                    div_q <= div_q + 1'b1;
                end
            end
        end
    end

    assign sck_o  = sck_q;
    assign mosi_o = shift_q[31];
    assign rx_o   = shift_q[7:0];
    assign fin_o  = fin_q;

endmodule : spi_shifter
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : rom_loader
//  Description : Wishbone initiator that copies `length` bytes from SPI flash
//                (read command 0x03 at flash_base) to wb_base onward, one
//                byte-wide Wishbone write per byte. CS stays low across all
//                bytes so the flash streams sequential data.
//  Ports       : clk, reset (async, active high)
//                start, flash_base, wb_base, length - transfer request
//                busy, done                         - status
//                spi_cs_n, spi_sck, spi_mosi, spi_miso - SPI flash
//                wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
//                wb_ack_i                           - Wishbone initiator
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [0:23] flash_base,
    input  logic [0:23] wb_base,
    input  logic [0:23] length,
    output logic        busy,
    output logic        done,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [0:23] wb_adr_o,
    output logic [0:7]  wb_dat_o,
    output logic        wb_we_o,
    output logic [0:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i
);
    state_t      state_q;
    logic        cs_n_q;
    logic        busy_q;
    logic        done_q;
    logic        cyc_q;
    logic [23:0] adr_q;
    logic [7:0]  dat_q;
    logic [23:0] cur_adr_q;   // wb_base + offset of the next byte
    logic [23:0] remain_q;

    logic        spi_run_d;
    logic [5:0]  spi_bits_d;
    logic [31:0] spi_tx_d;
    logic        spi_fin;
    logic [7:0]  spi_rx;

    // The shifter is (re)started on the same edge the FSM enters CMD or DATA,
    // so its load must be decoded combinationally from the current state.
    // flash_base is captured into the shift register by that load.
    always_comb begin
        spi_run_d  = 1'b0;
        spi_bits_d = BYTE_BITS;
        spi_tx_d   = 32'h0;
        case (state_q)
            ST_IDLE: begin
                spi_run_d  = start && (length != 24'd0);
                spi_bits_d = CMD_BITS;
                spi_tx_d   = {SPI_CMD_READ, flash_base};
            end
            ST_CMD:  spi_run_d = spi_fin;
            ST_WB:   spi_run_d = wb_ack_i && (remain_q != 24'd1);
            default: spi_run_d = 1'b0;
        endcase
    end

    spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk    (clk),
        .reset  (reset),
        .run_i  (spi_run_d),
        .bits_i (spi_bits_d),
        .tx_i   (spi_tx_d),
        .miso_i (spi_miso),
        .sck_o  (spi_sck),
        .mosi_o (spi_mosi),
        .rx_o   (spi_rx),
        .fin_o  (spi_fin)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cyc_q     <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            cur_adr_q <= '0;
            remain_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (length != 24'd0) begin
                            state_q   <= ST_CMD;
                            cs_n_q    <= 1'b0;
                            busy_q    <= 1'b1;
                            cur_adr_q <= wb_base;
                            remain_q  <= length;
                        end else begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_CMD: begin
                    if (spi_fin) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (spi_fin) begin
                        state_q <= ST_WB;
                        cyc_q   <= 1'b1;
                        adr_q   <= cur_adr_q;
                        dat_q   <= spi_rx;
                    end
                end
                ST_WB: begin
                    if (wb_ack_i) begin
                        cyc_q     <= 1'b0;
                        cur_adr_q <= cur_adr_q + 24'd1;
                        remain_q  <= remain_q - 24'd1;
                        if (remain_q == 24'd1) begin
                            // Completion is signalled on the ack edge so done,
                            // CS release and busy drop share one cycle.
                            state_q <= ST_FIN;
                            cs_n_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_FIN:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign spi_cs_n = cs_n_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    // Writes only: cyc, stb and we always move together.
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = cyc_q;
    assign wb_sel_o = 1'b1;

endmodule : rom_loader
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_loader
//  Description : Self-checking bench for rom_loader with a behavioural SPI
//                flash model, a Wishbone target with programmable ack wait
//                states and a scoreboard of expected (address, data) writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] flash_base = '0;
    logic [23:0] wb_base = '0;
    logic [23:0] length = '0;
    logic        busy, done, spi_cs_n, spi_sck, spi_mosi;
    logic        spi_miso = 1'b0;
    logic [23:0] wb_adr_o;
    logic [7:0]  wb_dat_o;
    logic        wb_we_o, wb_stb_o, wb_cyc_o;
    logic [0:0]  wb_sel_o;
    logic        wb_ack_i = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    rom_loader #(.CLK_DIV(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .flash_base (flash_base),
        .wb_base    (wb_base),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .spi_cs_n   (spi_cs_n),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_ack_i   (wb_ack_i)
    );

    always #5 clk = ~clk;

    // ---------------- flash model (mode 0) ----------------
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h012340: return 8'hA5;
            24'h012341: return 8'h5A;
            24'h012342: return 8'hFF;
            default:    return a[7:0] ^ 8'h3C;
        endcase
    endfunction

    int          fl_bits = 0;
    int          fl_k;
    logic [31:0] fl_cmd = '0;
    logic [7:0]  fl_byte;

    always @(negedge spi_cs_n or posedge spi_sck) begin
        if (!spi_sck) begin
            fl_bits = 0;
        end else begin
            if (fl_bits < 32) fl_cmd = {fl_cmd[30:0], spi_mosi};
            fl_bits = fl_bits + 1;
        end
    end

    always @(negedge spi_sck) begin
        if (!spi_cs_n && fl_bits >= 32) begin
            fl_k     = fl_bits - 32;
            fl_byte  = flash_byte(fl_cmd[23:0] + 24'(fl_k / 8));
            spi_miso = fl_byte[7 - (fl_k % 8)];
        end
    end

    // ---------------- scoreboard and transfer driver ----------------
    logic [31:0] exp_q[$];
    int t_done_cnt, t_done_cyc, t_cs_hi, t_sck_wb, t_activity, t_busy_after;

    task automatic do_transfer(input logic [23:0] fb, input logic [23:0] wb,
                               input logic [23:0] len, input int waits,
                               input int abort_acks, input int poke_at);
        int cyc, wcnt, acks, abort_cnt;
        bit fin;
        logic [31:0] exp;
        for (int i = 0; i < int'(len); i++)
            exp_q.push_back({wb + 24'(i), flash_byte(fb + 24'(i))});
        t_done_cnt = 0; t_done_cyc = -1; t_cs_hi = 0; t_sck_wb = 0;
        t_activity = 0; t_busy_after = 0;
        @(negedge clk);
        start = 1'b1; flash_base = fb; wb_base = wb; length = len;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        n_checks++;
        if ({busy, spi_cs_n, spi_mosi} !== ((len != 0) ? 3'b100 : 3'b010)) begin
            n_err++;
            $display("FAIL cycle1_status busy/cs_n/mosi got %b expected %b",
                     {busy, spi_cs_n, spi_mosi}, (len != 0) ? 3'b100 : 3'b010);
        end
        fin = 0; wcnt = 0; acks = 0; abort_cnt = 0;
        while (!fin) begin
            if (done) begin
                t_done_cnt++;
                if (t_done_cyc < 0) t_done_cyc = cyc;
            end
            if (busy && t_done_cyc >= 0) t_busy_after++;
            if (busy && spi_cs_n) t_cs_hi++;
            if (!spi_cs_n || spi_sck || wb_cyc_o) t_activity++;
            if (wb_cyc_o && wb_stb_o) begin
                if (spi_sck) t_sck_wb++;
                if (wcnt == waits) begin
                    wb_ack_i = 1'b1; wcnt = 0; acks++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL wb_write unexpected adr=%h dat=%h", wb_adr_o, wb_dat_o);
                    end else begin
                        exp = exp_q.pop_front();
                        if ({wb_we_o, wb_adr_o, wb_dat_o} !== {1'b1, exp}) begin
                            n_err++;
                            $display("FAIL wb_write got we=%b adr=%h dat=%h expected we=1 adr=%h dat=%h",
                                     wb_we_o, wb_adr_o, wb_dat_o, exp[31:8], exp[7:0]);
                        end
                    end
                end else begin
                    wb_ack_i = 1'b0; wcnt++;
                end
            end else begin
                wb_ack_i = 1'b0;
            end
            if (cyc == poke_at) begin
                start = 1'b1; wb_base = 24'h200000; length = 24'd1;
            end else if (cyc == poke_at + 1) begin
                start = 1'b0;
            end
            if (abort_acks > 0 && acks == abort_acks) begin
                abort_cnt++;
                if (abort_cnt == 12) fin = 1;
            end
            if (t_done_cyc >= 0 && cyc >= t_done_cyc + 3) fin = 1;
            if (cyc > 5000) begin
                n_checks++; n_err++;
                $display("FAIL timeout no done after %0d cycles", cyc);
                fin = 1;
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        wb_ack_i = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if ({spi_cs_n, spi_sck, spi_mosi, busy, done, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 9'b100000001) begin
            n_err++;
            $display("FAIL %s ctrl got %b expected 100000001", name,
                     {spi_cs_n, spi_sck, spi_mosi, busy, done, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o});
        end
        n_checks++;
        if ({wb_adr_o, wb_dat_o} !== 32'h0) begin
            n_err++;
            $display("FAIL %s adr/dat got %h/%h expected 000000/00", name, wb_adr_o, wb_dat_o);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle_after_reset");
    endtask

    int basic_done_cyc;

    task automatic test_basic();
        do_transfer(24'h012340, 24'h100000, 24'd3, 0, 0, -1);
        n_checks++;
        if (fl_cmd !== 32'h03012340) begin
            n_err++;
            $display("FAIL basic_mosi_cmd got %h expected 03012340", fl_cmd);
        end
        check_int("basic_done_count", t_done_cnt, 1);
        check_int("basic_cs_high_while_busy", t_cs_hi, 0);
        check_int("basic_queue_left", exp_q.size(), 0);
        basic_done_cyc = t_done_cyc;
    endtask

    task automatic test_wait_states();
        do_transfer(24'h012340, 24'h100000, 24'd3, 5, 0, -1);
        check_int("wait_done_count", t_done_cnt, 1);
        check_int("wait_extra_cycles", t_done_cyc - basic_done_cyc, 15);
        check_int("wait_sck_in_wb", t_sck_wb, 0);
        check_int("wait_queue_left", exp_q.size(), 0);
    endtask

    task automatic test_zero_length();
        do_transfer(24'h012340, 24'h100000, 24'd0, 0, 0, -1);
        check_int("zero_done_cycle", t_done_cyc, 1);
        check_int("zero_done_count", t_done_cnt, 1);
        check_int("zero_bus_activity", t_activity, 0);
    endtask

    task automatic test_wrap();
        do_transfer(24'h012340, 24'hFFFFFF, 24'd2, 1, 0, -1);
        check_int("wrap_done_count", t_done_cnt, 1);
        check_int("wrap_queue_left", exp_q.size(), 0);
    endtask

    task automatic test_reset_mid_and_ignored_start();
        do_transfer(24'h012340, 24'h300000, 24'd3, 0, 1, -1);
        n_checks++;
        if ({spi_cs_n, busy, wb_cyc_o} !== 3'b010) begin
            n_err++;
            $display("FAIL mid_byte2_state cs_n/busy/cyc got %b expected 010",
                     {spi_cs_n, busy, wb_cyc_o});
        end
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_mid_transfer");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        do_transfer(24'h012340, 24'h100000, 24'd3, 2, 0, 60);
        check_int("clean_done_count", t_done_cnt, 1);
        check_int("clean_queue_left", exp_q.size(), 0);
        check_int("ignored_start_busy_after_done", t_busy_after, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_zero_length();
        test_wrap();
        test_reset_mid_and_ignored_start();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_rom_loader
`default_nettype wire
